// File: rtl/sha256_mem_responder.sv
// Word-addressed memory model for a SHA-256 engine that also captures the 8-word digest the engine writes back.
// Read data is registered (1 cycle); no backpressure. Optional digest comparator under `DIGEST_CMP_EN.
module sha256_mem_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_we,
  input  logic [15:0]  mem_addr,
  input  logic [31:0]  mem_write_data,
  output logic [31:0]  mem_read_data,
  input  logic         host_we,
  input  logic [15:0]  host_addr,
  input  logic [31:0]  host_wdata,
  input  logic [15:0]  digest_base,
  input  logic         clear,
  output logic         digest_valid,
  output logic [255:0] digest,
`ifdef DIGEST_CMP_EN
  input  logic [255:0] expected_digest,
  output logic         digest_match,
  output logic         digest_mismatch,
`endif
  output logic         oor_err,
  output logic         seq_err,
  output logic         collision
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [16:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] ADDR_HI = {1'b0, BASE_ADDR} + 17'(DEPTH);

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_RUN  = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_t;

  // 17-bit compare so a window touching 16'hFFFF never wraps back to zero
  function automatic logic in_range(input logic [15:0] a);
    return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI);
  endfunction

  function automatic logic [AW-1:0] to_index(input logic [15:0] a);
    return AW'(a - BASE_ADDR);
  endfunction

  logic [31:0]   mem [DEPTH];
  logic          eng_ok;
  logic          host_ok;
  logic [AW-1:0] eng_idx;
  logic [AW-1:0] host_idx;
  logic          oor_hit;
  logic          coll_hit;

  cap_state_t    state_q;
  cap_state_t    state_d;
  logic [2:0]    k_q;
  logic [2:0]    k_d;
  logic          cap_wr;
  logic [2:0]    cap_slot;
  logic [7:0]    cap_lsb;
  logic          seq_hit;
  logic [255:0]  digest_q;

  assign eng_ok   = in_range(mem_addr);
  assign host_ok  = in_range(host_addr);
  assign eng_idx  = to_index(mem_addr);
  assign host_idx = to_index(host_addr);

  // The engine read port is live every cycle, so an out-of-range mem_addr counts even without mem_we
  assign oor_hit  = !eng_ok || (host_we && !host_ok);
  assign coll_hit = mem_we && host_we && (mem_addr == host_addr);

  // Engine write issued last so it wins a same-address conflict
  always_ff @(posedge clk) begin
    if (host_we && host_ok) mem[host_idx] <= host_wdata;
    if (mem_we && eng_ok)   mem[eng_idx]  <= mem_write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= 32'h0;
    end else begin
      mem_read_data <= eng_ok ? mem[eng_idx] : 32'hDEADBEEF;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cap_wr   = 1'b0;
    cap_slot = k_q;
    seq_hit  = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (mem_we && mem_addr == digest_base) begin
          cap_wr   = 1'b1;
          cap_slot = 3'd0;
          k_d      = 3'd1;
          state_d  = CAP_RUN;
        end
      end
      CAP_RUN: begin
        if (mem_we) begin
          if (mem_addr == digest_base + {13'd0, k_q}) begin
            cap_wr = 1'b1;
            k_d    = k_q + 3'd1;
            if (k_q == 3'd7) state_d = CAP_DONE;
          end else begin
            seq_hit = 1'b1;
            if (mem_addr == digest_base) begin
              cap_wr   = 1'b1;
              cap_slot = 3'd0;
              k_d      = 3'd1;
            end else begin
              k_d     = 3'd0;
              state_d = CAP_IDLE;
            end
          end
        end
      end
      CAP_DONE: state_d = CAP_IDLE;
      default: begin
        state_d = CAP_IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // Word 0 lands in the top 32 bits: ~slot == 7 - slot for a 3-bit slot
  assign cap_lsb = {~cap_slot, 5'd0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CAP_IDLE;
      k_q       <= 3'd0;
      digest_q  <= '0;
      oor_err   <= 1'b0;
      seq_err   <= 1'b0;
      collision <= 1'b0;
    end else if (clear) begin
      state_q   <= CAP_IDLE;
      k_q       <= 3'd0;
      digest_q  <= '0;
      oor_err   <= 1'b0;
      seq_err   <= 1'b0;
      collision <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      if (cap_wr) digest_q[cap_lsb +: 32] <= mem_write_data;
      oor_err   <= oor_err | oor_hit;
      seq_err   <= seq_err | seq_hit;
      collision <= collision | coll_hit;
    end
  end

  assign digest       = digest_q;
  assign digest_valid = (state_q == CAP_DONE);

`ifdef DIGEST_CMP_EN
  assign digest_match    = (state_q == CAP_DONE) && (digest_q == expected_digest);
  assign digest_mismatch = (state_q == CAP_DONE) && (digest_q != expected_digest);
`endif

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Scoreboard bench for sha256_mem_responder: reference model pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_sha256_mem_responder;
  localparam int DEPTH = 256;
  localparam int BASE  = 0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         mem_we = 1'b0;
  logic [15:0]  mem_addr = '0;
  logic [31:0]  mem_write_data = '0;
  logic [31:0]  mem_read_data;
  logic         host_we = 1'b0;
  logic [15:0]  host_addr = '0;
  logic [31:0]  host_wdata = '0;
  logic [15:0]  digest_base = '0;
  logic         clear = 1'b0;
  logic         digest_valid;
  logic [255:0] digest;
  logic         oor_err, seq_err, collision;
  logic [255:0] expected_digest = '0;
  logic         digest_match, digest_mismatch;

  always #5 clk = ~clk;

  sha256_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(16'(BASE))) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .digest_base(digest_base), .clear(clear),
    .digest_valid(digest_valid), .digest(digest),
`ifdef DIGEST_CMP_EN
    .expected_digest(expected_digest),
    .digest_match(digest_match), .digest_mismatch(digest_mismatch),
`endif
    .oor_err(oor_err), .seq_err(seq_err), .collision(collision)
  );

`ifndef DIGEST_CMP_EN
  initial begin
    digest_match    = 1'b0;
    digest_mismatch = 1'b0;
  end
`endif

  typedef struct {
    logic [31:0]  rd;
    bit           rd_known;
    bit           valid;
    logic [255:0] dig;
    bit           oor, seq, coll, match, mismatch;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: plain arrays and the list of digest words captured so far
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] words[$];
  logic [31:0] dig_w [8];
  bit          m_pulse, m_oor, m_seq, m_coll;

  function automatic bit in_rng(input logic [15:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
  endfunction

  task automatic model_step();
    exp_t        e;
    logic [15:0] want;
    bit          new_pulse;
    new_pulse = 1'b0;
    if (!reset_n) begin
      words.delete();
      foreach (dig_w[i]) dig_w[i] = '0;
      m_pulse = 0; m_oor = 0; m_seq = 0; m_coll = 0;
      e.rd = '0; e.rd_known = 1;
    end else begin
      if (in_rng(mem_addr)) begin
        e.rd       = ref_mem[int'(mem_addr) - BASE];
        e.rd_known = ref_known[int'(mem_addr) - BASE];
      end else begin
        e.rd = 32'hDEADBEEF; e.rd_known = 1;
      end
      if (clear) begin
        m_oor = 0; m_seq = 0; m_coll = 0;
        words.delete();
        foreach (dig_w[i]) dig_w[i] = '0;
      end else begin
        if (!in_rng(mem_addr) || (host_we && !in_rng(host_addr))) m_oor = 1;
        if (mem_we && host_we && mem_addr == host_addr) m_coll = 1;
        if (m_pulse) begin
          words.delete();
        end else if (mem_we) begin
          want = digest_base + 16'(words.size());
          if (mem_addr == want) begin
            dig_w[words.size()] = mem_write_data;
            words.push_back(mem_write_data);
            if (words.size() == 8) begin
              new_pulse = 1;
              words.delete();
            end
          end else if (words.size() != 0) begin
            m_seq = 1;
            words.delete();
            if (mem_addr == digest_base) begin
              dig_w[0] = mem_write_data;
              words.push_back(mem_write_data);
            end
          end
        end
      end
      if (host_we && in_rng(host_addr)) begin
        ref_mem[int'(host_addr) - BASE]   = host_wdata;
        ref_known[int'(host_addr) - BASE] = 1;
      end
      if (mem_we && in_rng(mem_addr)) begin
        ref_mem[int'(mem_addr) - BASE]   = mem_write_data;
        ref_known[int'(mem_addr) - BASE] = 1;
      end
      m_pulse = new_pulse;
    end
    e.dig = '0;
    for (int i = 0; i < 8; i++) e.dig = {e.dig[223:0], dig_w[i]};
    e.valid = m_pulse; e.oor = m_oor; e.seq = m_seq; e.coll = m_coll;
    e.match = 0; e.mismatch = 0;
`ifdef DIGEST_CMP_EN
    e.match    = m_pulse && (e.dig == expected_digest);
    e.mismatch = m_pulse && (e.dig != expected_digest);
`endif
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (e.rd_known) chk("mem_read_data", 256'(mem_read_data), 256'(e.rd));
        chk("digest_valid", 256'(digest_valid), 256'(e.valid));
        chk("digest", digest, e.dig);
        chk("oor_err", 256'(oor_err), 256'(e.oor));
        chk("seq_err", 256'(seq_err), 256'(e.seq));
        chk("collision", 256'(collision), 256'(e.coll));
`ifdef DIGEST_CMP_EN
        chk("digest_match", 256'(digest_match), 256'(e.match));
        chk("digest_mismatch", 256'(digest_mismatch), 256'(e.mismatch));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    mem_we = 0; host_we = 0; clear = 0; mem_addr = 16'h0000;
    repeat (n) tick();
  endtask

  task automatic eng_wr(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1; mem_addr = a; mem_write_data = d;
    tick();
    mem_we = 0; mem_addr = 16'h0000;
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 9) != 0) return 16'($urandom_range(0, DEPTH - 1));
    return 16'($urandom_range(DEPTH, 16'hFFFF));
  endfunction

  function automatic logic [255:0] a_digest();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'hA0 + 32'(i)};
    return v;
  endfunction

  initial begin
    logic [15:0] cap_pos;
    int          cap_left;
    int          drain;
    cap_pos = '0; cap_left = 0;

    idle(3);
    reset_n = 1;
    idle(2);

    // Preload the whole array so every later read has a known value
    for (int n = 0; n < DEPTH; n++) begin
      host_we = 1; host_addr = 16'(n); host_wdata = 32'h1000 + 32'(n);
      tick();
    end
    host_we = 0; mem_addr = 16'd5;
    tick();
    idle(1);

    digest_base = 16'h0080;
    for (int pass = 0; pass < 2; pass++) begin
      expected_digest = a_digest();
      if (pass == 1) expected_digest[17] = ~expected_digest[17];
      for (int i = 0; i < 8; i++) eng_wr(16'h0080 + 16'(i), 32'hA0 + 32'(i));
      idle(3);
    end

    eng_wr(16'h0080, 32'h11); eng_wr(16'h0081, 32'h22); eng_wr(16'h0090, 32'h33);
    idle(2);
    clear = 1; tick(); clear = 0;
    idle(1);

    host_we = 1; host_addr = 16'd3; host_wdata = 32'h1111;
    mem_we = 1; mem_addr = 16'd3; mem_write_data = 32'h2222;
    tick();
    host_we = 0; mem_we = 0;
    tick();
    idle(1);

    mem_addr = 16'h0100; tick();
    idle(1);
    for (int i = 0; i < 4; i++) eng_wr(16'h0080 + 16'(i), 32'hB0 + 32'(i));
    @(negedge clk); #1;
    reset_n = 0;
    tick();
    reset_n = 1;
    idle(4);

    for (int c = 0; c < 3000; c++) begin
      host_we    = ($urandom_range(0, 3) == 0);
      host_addr  = rnd_addr();
      host_wdata = $urandom;
      clear      = ($urandom_range(0, 199) == 0);
      mem_write_data = $urandom;
      if (cap_left > 0 && $urandom_range(0, 2) != 0) begin
        mem_we   = 1;
        mem_addr = ($urandom_range(0, 19) == 0) ? rnd_addr() : digest_base + cap_pos;
        cap_pos  = cap_pos + 16'd1;
        cap_left--;
      end else if (cap_left == 0 && $urandom_range(0, 19) == 0) begin
        digest_base = ($urandom_range(0, 4) == 0) ? 16'hFFFC : 16'($urandom_range(0, DEPTH - 8));
        cap_pos = '0; cap_left = 8;
        mem_we = 0; mem_addr = rnd_addr();
      end else begin
        mem_we   = ($urandom_range(0, 2) == 0);
        mem_addr = rnd_addr();
      end
      if ($urandom_range(0, 15) == 0) host_addr = mem_addr;
      tick();
    end
    idle(4);

    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
